pc_predictor_gshare: RTL
========================

Name: pc_predictor_gshare

Overview:
- Parametrised successor to the fetch-side next-PC generator with branch prediction.
- Computes the next fetch address from the last fetched PC and instruction, and predicts conditional branches with a table of N-bit saturating counters.
- Table index is either PC-only (bimodal) or PC XOR committed global history (gshare).
- Takes resolved-branch updates and misbranch redirects from the branch-info forwarding path; raises the pipeline flush.

Parameters:
- INDEX_BITS, 8, log2 of prediction table depth (256 entries).
- CTR_BITS, 2, saturating counter width; 2..4.
- HIST_LEN, 8, global history register length; 1..INDEX_BITS.
- INDEX_MODE, 1, 0 = bimodal (PC bits only), 1 = gshare (PC bits XOR history).
- RESET_PC, 32'h0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  global enable; when low, no state changes.
- in_fetcher_ena  in  1  fetcher accepts a new address this cycle.
- in_last_pc  in  32  PC of the instruction just fetched.
- in_last_inst  in  32  instruction just fetched.
- out_next_pc  out  32  registered next fetch address.
- out_next_taken  out  1  registered prediction attached to out_next_pc.
- in_update_valid  in  1  a conditional branch resolved this cycle.
- in_update_pc  in  32  PC of the resolved branch.
- in_update_taken  in  1  actual outcome of the resolved branch.
- in_misbranch  in  1  resolved branch was mispredicted.
- in_correct_address  in  32  redirect target on misbranch.
- out_clear_all  out  1  flush request for all components.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_next_pc = RESET_PC; out_next_taken = 0; history = 0.
  - Every counter = 2^(CTR_BITS-1)-1 (weakly not-taken; 2'b01 for CTR_BITS=2).
  - Reset asserted mid-operation overrides any in-flight update or redirect.
- Index computation:
  - pc_idx(x) = x[INDEX_BITS+1:2].
  - Mode 0: idx = pc_idx.
  - Mode 1: idx = pc_idx XOR {zero-extend history to INDEX_BITS}.
  - Prediction and update both use the committed history value present at the start of the cycle.
- Prediction: predict = MSB of the counter at idx(in_last_pc).
- Next PC, registered when ena && in_fetcher_ena; priority in this order:
  1. in_misbranch -> out_next_pc = in_correct_address; out_next_taken = 0.
  2. Opcode 7'b1100011 (branch) -> in_last_pc + B_IMM if predict, else in_last_pc + 4; out_next_taken = predict.
  3. Opcode 7'b1101111 (JAL) -> in_last_pc + J_IMM; out_next_taken = 1.
  4. Anything else, including JALR -> in_last_pc + 4; out_next_taken = 0.
  - B_IMM and J_IMM are sign-extended RV32I immediates. Addition is 32-bit modulo; wrap at 2^32 is legal.
- Hold: ena low or in_fetcher_ena low -> out_next_pc and out_next_taken hold.
- Misbranch while in_fetcher_ena is low: the redirect is still taken, so a redirect is never lost.
  - When ena=1 and in_misbranch=1, out_next_pc loads in_correct_address even if in_fetcher_ena=0.
- Counter update, when ena && in_update_valid, independent of in_fetcher_ena:
  - Counter at idx(in_update_pc): +1 if taken, -1 if not taken.
  - Saturate at 2^CTR_BITS-1 and 0; no wrap.
- History update, same condition: history <= {history[HIST_LEN-2:0], in_update_taken}.
  - For HIST_LEN=1, history <= in_update_taken.
- Same-cycle read and write to the same index: the prediction uses the pre-update counter value; the write lands at the clock edge.
- out_clear_all = in_misbranch, combinational, not gated by ena.
- Latency: one cycle from in_last_pc/in_last_inst to out_next_pc; one cycle from an update to the counter being visible.

Test Plan:
- Reset: hold rst_n=0, release.
  - out_next_pc=0, out_next_taken=0.
  - First branch at PC 0x100, inst 32'h00208463 (beq +8) -> next 0x104, taken=0.
- Saturation up, INDEX_MODE=0, CTR_BITS=2:
  - Three taken updates at PC 0x100; fetch beq at 0x100 -> next 0x108, taken=1.
  - Further taken updates leave the counter at 2'b11 (no wrap to 0).
- Saturation down: five not-taken updates at 0x100 -> counter 2'b00, prediction 0x104.
  - One taken update -> 2'b01, still predicts 0x104.
- Gshare aliasing, INDEX_MODE=1:
  - Updates taken,taken at PC 0x200 -> history=2'b11.
  - Fetch at 0x200 reads idx 0x80^0x03=0x83, not 0x80; verify by pre-training entry 0x83 to strongly taken.
- Misbranch priority: in_misbranch=1, in_correct_address=0x3000, with a JAL in flight and in_fetcher_ena=0.
  - out_next_pc=0x3000 next cycle; out_clear_all=1 in the same cycle.
- JAL/JALR/wrap and stall:
  - JAL at 0xFFFFFFFC with +8 -> 0x00000004.
  - JALR at 0x40 -> 0x44.
  - ena=0 for 3 cycles -> all outputs and counters hold.

Source files
------------

// File: rtl/pc_predictor_gshare.sv
// pc_predictor_gshare: next-PC generator with bimodal/gshare saturating-counter branch prediction
module pc_predictor_gshare #(
  parameter int          INDEX_BITS = 8,
  parameter int          CTR_BITS   = 2,
  parameter int          HIST_LEN   = 8,
  parameter int          INDEX_MODE = 1,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        in_fetcher_ena,
  input  logic [31:0] in_last_pc,
  input  logic [31:0] in_last_inst,
  output logic [31:0] out_next_pc,
  output logic        out_next_taken,
  input  logic        in_update_valid,
  input  logic [31:0] in_update_pc,
  input  logic        in_update_taken,
  input  logic        in_misbranch,
  input  logic [31:0] in_correct_address,
  output logic        out_clear_all
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  logic [CTR_BITS-1:0]   ctr [DEPTH];
  logic [HIST_LEN-1:0]   hist, hist_next;
  logic [INDEX_BITS-1:0] hist_mix, fetch_idx, upd_idx;
  logic [CTR_BITS-1:0]   upd_cur, upd_next;
  logic [31:0]           b_imm, j_imm, next_pc;
  logic                  predict, is_branch, is_jal, next_taken;
  logic                  unused_bits;
  assign unused_bits = ^{in_update_pc[31:INDEX_BITS+2], in_update_pc[1:0]};
  assign hist_mix  = (INDEX_MODE != 0) ? INDEX_BITS'(hist) : '0;
  assign fetch_idx = in_last_pc[INDEX_BITS+1:2] ^ hist_mix;
  assign upd_idx   = in_update_pc[INDEX_BITS+1:2] ^ hist_mix;
  assign predict   = ctr[fetch_idx][CTR_BITS-1];
  assign upd_cur   = ctr[upd_idx];
  assign upd_next  = in_update_taken ? ((upd_cur == CTR_MAX) ? upd_cur : upd_cur + 1'b1)
                                     : ((upd_cur == '0) ? upd_cur : upd_cur - 1'b1);
  // Shifting through a one-bit-wider vector keeps HIST_LEN=1 legal
  assign hist_next = HIST_LEN'({hist, in_update_taken});
  assign b_imm = {{20{in_last_inst[31]}}, in_last_inst[7], in_last_inst[30:25], in_last_inst[11:8], 1'b0};
  assign j_imm = {{12{in_last_inst[31]}}, in_last_inst[19:12], in_last_inst[20], in_last_inst[30:21], 1'b0};
  assign is_branch  = in_last_inst[6:0] == 7'b1100011;
  assign is_jal     = in_last_inst[6:0] == 7'b1101111;
  assign next_pc    = is_branch ? (predict ? in_last_pc + b_imm : in_last_pc + 32'd4)
                    : is_jal ? in_last_pc + j_imm : in_last_pc + 32'd4;
  assign next_taken = is_branch ? predict : is_jal;
  assign out_clear_all = in_misbranch;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_next_pc    <= RESET_PC;
      out_next_taken <= 1'b0;
      hist           <= '0;
      for (int i = 0; i < DEPTH; i++) ctr[i] <= CTR_INIT;
    end else if (ena) begin
      if (in_misbranch) begin
        out_next_pc    <= in_correct_address;
        out_next_taken <= 1'b0;
      end else if (in_fetcher_ena) begin
        out_next_pc    <= next_pc;
        out_next_taken <= next_taken;
      end
      if (in_update_valid) begin
        ctr[upd_idx] <= upd_next;
        hist         <= hist_next;
      end
    end
  end
endmodule
